// File: rtl/bitop_pkg.sv
// bitop_pkg: opcode and sequencer state types shared by the bitop scheduler
package bitop_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_XNOR} bitop_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of first req at or above ptr (wrapping); outputs grant_oh, grant_idx, any
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_idx,
  output logic         any
);
  logic [W-1:0] idx;
  always_comb begin
    idx = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      grant_idx = req[idx] ? idx : grant_idx;
    end
    any = |req;
    grant_oh = any ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/bitop_share_sched.sv
// bitop_share_sched: round-robin shared AND/OR/XOR/XNOR unit; req_valid/ready/op/a/b in, rsp_valid/ready/id/data out, saturating ops_done count
module bitop_share_sched
  import bitop_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][1:0]        req_op,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [IW-1:0]                  rsp_id,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [15:0]                    ops_done
);
  sched_state_e      state, state_nx;
  bitop_e            op_q;
  logic [DATA_W-1:0] a_q, b_q, res;
  logic [IW-1:0]     gnt_q, rr_ptr, grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic              any;
  rr_arbiter #(.N(NUM_REQ), .W(IW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant_oh(grant_oh),
    .grant_idx(grant_idx),
    .any(any)
  );
  always_comb begin
    req_ready = (state == S_IDLE && rst_n) ? grant_oh : '0;
    state_nx = (state == S_IDLE) ? (any ? S_EXEC : S_IDLE) :
               (state == S_EXEC) ? S_RESP :
               (state == S_RESP && !rsp_ready) ? S_RESP : S_IDLE;
  end
  always_comb begin
    res = '0;
    case (op_q)
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_XNOR: res = ~(a_q ^ b_q);
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any) begin
        op_q <= bitop_e'(req_op[grant_idx]);
        a_q <= req_a[grant_idx];
        b_q <= req_b[grant_idx];
        gnt_q <= grant_idx;
      end
      if (state == S_EXEC) begin
        rsp_data <= res;
        rsp_id <= gnt_q;
        rsp_valid <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bitop_share_sched.sv
// tb_bitop_share_sched: table-driven and sequence checks of the shared bitop scheduler
module tb_bitop_share_sched;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid, req_ready;
  logic [3:0][1:0] req_op;
  logic [3:0][15:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data, ops_done;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [15:0] a, b, exp;
  } vec_t;
  vec_t tbl[8];
  bitop_share_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .ops_done(ops_done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_valid = 4'(1 << v.idx);
    req_op[v.idx] = v.op;
    req_a[v.idx] = v.a;
    req_b[v.idx] = v.b;
    rsp_ready = 1'b1;
    #1 chk("req_ready", 32'(req_ready), 32'(1 << v.idx));
    @(negedge clk);
    req_valid = '0;
    chk("exec_no_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(v.idx));
    chk("rsp_data", 32'(rsp_data), 32'(v.exp));
  endtask
  initial begin
    tbl[0] = '{1, 2'b10, 16'hF0F0, 16'h0FF0, 16'hFF00};
    tbl[1] = '{0, 2'b00, 16'hAAAA, 16'hCCCC, 16'h8888};
    tbl[2] = '{1, 2'b01, 16'hAAAA, 16'hCCCC, 16'hEEEE};
    tbl[3] = '{2, 2'b10, 16'hAAAA, 16'hCCCC, 16'h6666};
    tbl[4] = '{3, 2'b11, 16'hAAAA, 16'hCCCC, 16'h9999};
    tbl[5] = '{3, 2'b00, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[6] = '{2, 2'b11, 16'h1234, 16'h1234, 16'hFFFF};
    tbl[7] = '{0, 2'b01, 16'h0000, 16'h0000, 16'h0000};
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    req_valid = '0;
    rst_n = 1'b1;
    foreach (tbl[i]) run_vec(tbl[i]);
    @(negedge clk);
    chk("ops_done_8", 32'(ops_done), 8);
    req_valid = 4'b1000;
    req_op[3] = 2'b00;
    req_a[3] = 16'h1234;
    req_b[3] = 16'hFFFF;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ops_done", 32'(ops_done), 0);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_op[i] = 2'b10;
      req_a[i] = 16'(16'h1111 * (i + 1));
      req_b[i] = 16'h00FF;
    end
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      @(negedge clk);
      chk("rr_exec_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
      chk("rr_rsp_data", 32'(rsp_data), 32'(16'(16'h1111 * ((g % 4) + 1)) ^ 16'h00FF));
      @(negedge clk);
    end
    req_valid = 4'b0001;
    req_op[0] = 2'b01;
    req_a[0] = 16'h0F00;
    req_b[0] = 16'h00F0;
    rsp_ready = 1'b0;
    #1 chk("bp_grant0", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 4'b0100;
    req_op[2] = 2'b11;
    req_a[2] = 16'h0000;
    req_b[2] = 16'h0000;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h0FF0);
      chk("bp_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(rsp_valid), 0);
    chk("bp_grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp_rsp2_id", 32'(rsp_id), 2);
    chk("bp_rsp2_data", 32'(rsp_data), 32'hFFFF);
    @(negedge clk);
    force dut.ops_done = 16'hFFFE;
    @(negedge clk);
    release dut.ops_done;
    run_vec(tbl[1]);
    @(negedge clk);
    chk("sat_first", 32'(ops_done), 32'hFFFF);
    run_vec(tbl[2]);
    run_vec(tbl[3]);
    @(negedge clk);
    chk("sat_hold", 32'(ops_done), 32'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
